// File: rtl/ctrl_cmd_arb.sv
// DDR command-bus arbiter: grants one of REF/CAS/PRE/ACT per clock and registers it onto the bus.
// Enforces tRRD, tFAW (four-ACT rolling window) and the tRFC lockout that follows a refresh.
//
// state        | meaning
// ARB_RUN      | arbitrating normally, one grant per clock at most
// ARB_REF_LOCK | refresh in progress, no grants until rfc_cnt reaches 0
module ctrl_cmd_arb #(
    parameter int BANK_W = 4,
    parameter int ROW_W  = 17,
    parameter int COL_W  = 10,
    parameter int TRRD   = 4,
    parameter int TFAW   = 16,
    parameter int TRFC   = 32
) (
    input  logic              CK_t,
    input  logic              reset_n,
    input  logic              ref_req,
    output logic              ref_gnt,
    input  logic              pre_req,
    input  logic [BANK_W-1:0] pre_bank,
    output logic              pre_gnt,
    input  logic              act_req,
    input  logic [BANK_W-1:0] act_bank,
    input  logic [ROW_W-1:0]  act_row,
    output logic              act_gnt,
    input  logic              cas_req,
    input  logic [2:0]        cas_cmd,
    input  logic [BANK_W-1:0] cas_bank,
    input  logic [COL_W-1:0]  cas_col,
    output logic              cas_gnt,
    output logic              cmd_vld,
    output logic [2:0]        cmd_code,
    output logic [BANK_W-1:0] cmd_bank,
    output logic [ROW_W-1:0]  cmd_addr,
    output logic              cas_err,
    output logic              ref_busy
);

    localparam int T_MAX_A = (TRRD > TFAW) ? TRRD : TFAW;
    localparam int T_MAX   = (T_MAX_A > TRFC) ? T_MAX_A : TRFC;
    localparam int CW      = $clog2(T_MAX) + 1;

    localparam logic [2:0] CODE_NOP = 3'd0;
    localparam logic [2:0] CODE_ACT = 3'd1;
    localparam logic [2:0] CODE_PRE = 3'd6;
    localparam logic [2:0] CODE_REF = 3'd7;

    typedef enum logic {
        ARB_RUN      = 1'b0,
        ARB_REF_LOCK = 1'b1
    } arb_state_e;

    arb_state_e        state_q, state_d;
    logic [CW-1:0]     trrd_q, trrd_d;
    logic [CW-1:0]     rfc_q, rfc_d;
    logic [CW-1:0]     faw_q [4];
    logic [CW-1:0]     faw_d [4];

    logic              ref_gnt_q, ref_gnt_d;
    logic              pre_gnt_q, pre_gnt_d;
    logic              act_gnt_q, act_gnt_d;
    logic              cas_gnt_q, cas_gnt_d;
    logic              cmd_vld_q, cmd_vld_d;
    logic [2:0]        cmd_code_q, cmd_code_d;
    logic [BANK_W-1:0] cmd_bank_q, cmd_bank_d;
    logic [ROW_W-1:0]  cmd_addr_q, cmd_addr_d;
    logic              cas_err_q, cas_err_d;
    logic              ref_busy_q, ref_busy_d;

    logic              can_arb;
    logic              cas_cmd_ok;
    logic              faw_free;
    logic [1:0]        faw_sel;
    logic              ref_win, cas_win, pre_win, act_win;

    always_comb begin
        faw_free = 1'b0;
        faw_sel  = 2'd0;
        // Scan high to low so the last hit is the lowest free slot.
        for (int i = 3; i >= 0; i--) begin
            if (faw_q[i] == '0) begin
                faw_free = 1'b1;
                faw_sel  = 2'(i);
            end
        end
    end

    always_comb begin
        cas_cmd_ok = (cas_cmd >= 3'd2) && (cas_cmd <= 3'd5);
        // Lockout releases in the same cycle rfc_cnt hits zero.
        can_arb    = (state_q == ARB_RUN) || (rfc_q == '0);

        ref_win = can_arb && ref_req && !ref_gnt_q;
        cas_win = can_arb && !ref_win && cas_req && cas_cmd_ok && !cas_gnt_q;
        pre_win = can_arb && !ref_win && !cas_win && pre_req && !pre_gnt_q;
        act_win = can_arb && !ref_win && !cas_win && !pre_win && act_req && !act_gnt_q
                  && (trrd_q == '0) && faw_free;
    end

    always_comb begin
        state_d    = state_q;
        ref_gnt_d  = ref_win;
        cas_gnt_d  = cas_win;
        pre_gnt_d  = pre_win;
        act_gnt_d  = act_win;
        cmd_vld_d  = ref_win || cas_win || pre_win || act_win;
        cmd_code_d = CODE_NOP;
        cmd_bank_d = '0;
        cmd_addr_d = '0;
        cas_err_d  = cas_req && !cas_cmd_ok;

        trrd_d = (trrd_q != '0) ? trrd_q - 1'b1 : '0;
        rfc_d  = (rfc_q != '0) ? rfc_q - 1'b1 : '0;
        for (int i = 0; i < 4; i++) begin
            faw_d[i] = (faw_q[i] != '0) ? faw_q[i] - 1'b1 : '0;
        end

        if (ref_win) begin
            cmd_code_d = CODE_REF;
            rfc_d      = CW'(TRFC - 1);
            state_d    = ARB_REF_LOCK;
        end else if (cas_win) begin
            cmd_code_d = cas_cmd;
            cmd_bank_d = cas_bank;
            cmd_addr_d = ROW_W'(cas_col);
        end else if (pre_win) begin
            cmd_code_d = CODE_PRE;
            cmd_bank_d = pre_bank;
        end else if (act_win) begin
            cmd_code_d     = CODE_ACT;
            cmd_bank_d     = act_bank;
            cmd_addr_d     = act_row;
            trrd_d         = CW'(TRRD - 1);
            faw_d[faw_sel] = CW'(TFAW - 1);
        end

        if (!ref_win && (state_q == ARB_REF_LOCK) && (rfc_q == '0)) begin
            state_d = ARB_RUN;
        end

        ref_busy_d = (state_d == ARB_REF_LOCK);
    end

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_RUN;
            trrd_q     <= '0;
            rfc_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                faw_q[i] <= '0;
            end
            ref_gnt_q  <= 1'b0;
            pre_gnt_q  <= 1'b0;
            act_gnt_q  <= 1'b0;
            cas_gnt_q  <= 1'b0;
            cmd_vld_q  <= 1'b0;
            cmd_code_q <= CODE_NOP;
            cmd_bank_q <= '0;
            cmd_addr_q <= '0;
            cas_err_q  <= 1'b0;
            ref_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            trrd_q     <= trrd_d;
            rfc_q      <= rfc_d;
            for (int i = 0; i < 4; i++) begin
                faw_q[i] <= faw_d[i];
            end
            ref_gnt_q  <= ref_gnt_d;
            pre_gnt_q  <= pre_gnt_d;
            act_gnt_q  <= act_gnt_d;
            cas_gnt_q  <= cas_gnt_d;
            cmd_vld_q  <= cmd_vld_d;
            cmd_code_q <= cmd_code_d;
            cmd_bank_q <= cmd_bank_d;
            cmd_addr_q <= cmd_addr_d;
            cas_err_q  <= cas_err_d;
            ref_busy_q <= ref_busy_d;
        end
    end

    assign ref_gnt  = ref_gnt_q;
    assign pre_gnt  = pre_gnt_q;
    assign act_gnt  = act_gnt_q;
    assign cas_gnt  = cas_gnt_q;
    assign cmd_vld  = cmd_vld_q;
    assign cmd_code = cmd_code_q;
    assign cmd_bank = cmd_bank_q;
    assign cmd_addr = cmd_addr_q;
    assign cas_err  = cas_err_q;
    assign ref_busy = ref_busy_q;

endmodule

// File: tb/tb_ctrl_cmd_arb.sv
// Directed bench for ctrl_cmd_arb: reset, priority, refresh lockout, ACT spacing, illegal CAS, reset mid-lockout.
module tb_ctrl_cmd_arb;

    localparam int BANK_W = 4;
    localparam int ROW_W  = 17;
    localparam int COL_W  = 10;

    logic              CK_t = 1'b0;
    logic              reset_n;
    logic              ref_req, pre_req, act_req, cas_req;
    logic [BANK_W-1:0] pre_bank, act_bank, cas_bank;
    logic [ROW_W-1:0]  act_row;
    logic [2:0]        cas_cmd;
    logic [COL_W-1:0]  cas_col;
    logic              ref_gnt, pre_gnt, act_gnt, cas_gnt;
    logic              cmd_vld, cas_err, ref_busy;
    logic [2:0]        cmd_code;
    logic [BANK_W-1:0] cmd_bank;
    logic [ROW_W-1:0]  cmd_addr;

    int n_chk  = 0;
    int n_pass = 0;

    ctrl_cmd_arb #(
        .BANK_W(BANK_W), .ROW_W(ROW_W), .COL_W(COL_W),
        .TRRD(4), .TFAW(16), .TRFC(32)
    ) dut (
        .CK_t(CK_t), .reset_n(reset_n),
        .ref_req(ref_req), .ref_gnt(ref_gnt),
        .pre_req(pre_req), .pre_bank(pre_bank), .pre_gnt(pre_gnt),
        .act_req(act_req), .act_bank(act_bank), .act_row(act_row), .act_gnt(act_gnt),
        .cas_req(cas_req), .cas_cmd(cas_cmd), .cas_bank(cas_bank), .cas_col(cas_col),
        .cas_gnt(cas_gnt),
        .cmd_vld(cmd_vld), .cmd_code(cmd_code), .cmd_bank(cmd_bank), .cmd_addr(cmd_addr),
        .cas_err(cas_err), .ref_busy(ref_busy)
    );

    always #5 CK_t = ~CK_t;

    task automatic tick();
        @(posedge CK_t);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    initial begin
        int bad;
        logic exp_g;

        // Reset with every request asserted
        reset_n  = 1'b0;
        ref_req  = 1'b1;
        pre_req  = 1'b1;  pre_bank = 4'd5;
        act_req  = 1'b1;  act_bank = 4'd1;  act_row = 17'h1ABCD;
        cas_req  = 1'b1;  cas_cmd  = 3'd2;  cas_bank = 4'd3;  cas_col = 10'h012;
        tick(); tick();
        chk("rst_ref_gnt", 32'(ref_gnt), 32'd0);
        chk("rst_cmd_vld", 32'(cmd_vld), 32'd0);
        chk("rst_cmd_code", 32'(cmd_code), 32'd0);
        chk("rst_gnts", {28'd0, act_gnt, cas_gnt, pre_gnt, ref_gnt}, 32'd0);
        chk("rst_ref_busy", 32'(ref_busy), 32'd0);

        // All four requesting: REF wins, then lockout, then CAS > PRE > ACT
        reset_n = 1'b1;
        tick();
        chk("ref_first_gnt", 32'(ref_gnt), 32'd1);
        chk("ref_first_code", 32'(cmd_code), 32'd7);
        chk("ref_first_busy", 32'(ref_busy), 32'd1);
        chk("ref_first_others", {29'd0, act_gnt, cas_gnt, pre_gnt}, 32'd0);
        ref_req = 1'b0;
        bad = 0;
        for (int c = 2; c <= 32; c++) begin
            tick();
            if (cmd_vld !== 1'b0 || ref_busy !== 1'b1) bad++;
        end
        chk("lockout_quiet_cycles", 32'(bad), 32'd0);
        tick();
        chk("cas_after_lock_gnt", 32'(cas_gnt), 32'd1);
        chk("cas_after_lock_code", 32'(cmd_code), 32'd2);
        chk("cas_after_lock_addr", 32'(cmd_addr), 32'h12);
        chk("cas_after_lock_bank", 32'(cmd_bank), 32'd3);
        chk("cas_after_lock_busy", 32'(ref_busy), 32'd0);
        cas_req = 1'b0;
        tick();
        chk("pre_second_code", 32'(cmd_code), 32'd6);
        chk("pre_second_bank", 32'(cmd_bank), 32'd5);
        chk("pre_second_addr", 32'(cmd_addr), 32'd0);
        pre_req = 1'b0;
        tick();
        chk("act_third_code", 32'(cmd_code), 32'd1);
        chk("act_third_addr", 32'(cmd_addr), 32'h1ABCD);
        chk("act_third_gnt", 32'(act_gnt), 32'd1);
        act_req = 1'b0;
        tick();
        chk("idle_cmd_vld", 32'(cmd_vld), 32'd0);
        chk("idle_cmd_code", 32'(cmd_code), 32'd0);

        // ACT spacing: tRRD=4 gives 1,5,9,13; 5th held to 1+tFAW=17
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        act_req = 1'b1; act_bank = 4'd2; act_row = 17'h00F0F;
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp_g = (e == 1 || e == 5 || e == 9 || e == 13 || e == 17);
            chk($sformatf("act_spacing_c%0d", e), 32'(act_gnt), 32'(exp_g));
        end
        act_req = 1'b0;
        tick();

        // Illegal CAS opcode held 3 cycles
        cas_req = 1'b1; cas_cmd = 3'd7; cas_col = 10'h3FF;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("ill_cas_err_c%0d", c), 32'(cas_err), 32'd1);
            chk($sformatf("ill_cas_bus_c%0d", c), {30'd0, cas_gnt, cmd_vld}, 32'd0);
        end
        cas_req = 1'b0;
        tick();
        chk("ill_cas_err_clear", 32'(cas_err), 32'd0);

        // WR with pre_req tied: CAS beats PRE, column zero-extended
        cas_req = 1'b1; cas_cmd = 3'd4; cas_bank = 4'd9; cas_col = 10'h2A5;
        pre_req = 1'b1; pre_bank = 4'd7;
        tick();
        chk("wr_code", 32'(cmd_code), 32'd4);
        chk("wr_addr", 32'(cmd_addr), 32'h2A5);
        chk("wr_pre_lost", 32'(pre_gnt), 32'd0);
        cas_req = 1'b0;
        tick();
        chk("pre_after_wr_gnt", 32'(pre_gnt), 32'd1);
        pre_req = 1'b0;
        tick();

        // Reset in the middle of a refresh lockout
        ref_req = 1'b1;
        tick();
        chk("lock2_ref_gnt", 32'(ref_gnt), 32'd1);
        ref_req = 1'b0;
        cas_req = 1'b1; cas_cmd = 3'd3; cas_bank = 4'd4; cas_col = 10'h055;
        for (int c = 2; c <= 10; c++) tick();
        chk("lock2_busy_c10", 32'(ref_busy), 32'd1);
        chk("lock2_cas_blocked", 32'(cas_gnt), 32'd0);
        reset_n = 1'b0;
        tick(); tick();
        chk("midlock_rst_busy", 32'(ref_busy), 32'd0);
        chk("midlock_rst_vld", 32'(cmd_vld), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_cas_gnt", 32'(cas_gnt), 32'd1);
        chk("post_rst_cas_code", 32'(cmd_code), 32'd3);
        chk("post_rst_cas_addr", 32'(cmd_addr), 32'h55);
        cas_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
